// File: rtl/ram_write_buffer.sv
// In-order store buffer between the load/store unit and the data RAM write port.
// Also reports read hazards when a buffered store targets the word being read.
module ram_write_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    input  logic [DATA_WIDTH-1:0]     req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   req_be_i,
    output logic                      ram_we_o,
    input  logic                      ram_gnt_i,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    input  logic [ADDR_WIDTH-1:0]     rd_addr_i,
    output logic                      rd_hazard_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      empty_o
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int BW  = DATA_WIDTH / 8;
    localparam int OFS = $clog2(BW);

    logic [ADDR_WIDTH-1:0] r_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] r_wdata [DEPTH];
    logic [BW-1:0]         r_be    [DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_ready;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH-1:0]      w_hit;

    assign w_ready = (r_count < CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Zero byte enables complete the handshake but leave nothing to write.
    assign w_push  = req_valid_i && w_ready && (req_be_i != '0);
    assign w_pop   = !w_empty && ram_gnt_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]  <= '0;
                r_wdata[i] <= '0;
                r_be[i]    <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_wr_ptr]  <= req_addr_i;
                r_wdata[r_wr_ptr] <= req_wdata_i;
                r_be[r_wr_ptr]    <= req_be_i;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
            logic [PW-1:0] w_rel;
            assign w_rel     = PW'(gi) - r_rd_ptr;
            assign w_hit[gi] = ({1'b0, w_rel} < r_count) &&
                               (r_addr[gi][ADDR_WIDTH-1:OFS] == rd_addr_i[ADDR_WIDTH-1:OFS]);
        end
    endgenerate

    assign rd_hazard_o = |w_hit;
    assign req_ready_o = w_ready;
    assign ram_we_o    = !w_empty;
    assign ram_addr_o  = w_empty ? '0 : r_addr[r_rd_ptr];
    assign ram_wdata_o = w_empty ? '0 : r_wdata[r_rd_ptr];
    assign ram_be_o    = w_empty ? '0 : r_be[r_rd_ptr];
    assign count_o     = r_count;
    assign empty_o     = w_empty;
endmodule

// File: tb/tb_ram_write_buffer.sv
// Directed bench for ram_write_buffer: reset, drain ordering, backpressure,
// wrap-around streaming, read hazards, zero-byte-enable stores and async reset.
module tb_ram_write_buffer;
    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        ram_we_o;
    logic        ram_gnt_i;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_be_o;
    logic [31:0] rd_addr_i;
    logic        rd_hazard_o;
    logic [2:0]  count_o;
    logic        empty_o;

    int checks   = 0;
    int failures = 0;

    ram_write_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .ram_we_o(ram_we_o), .ram_gnt_i(ram_gnt_i),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o),
        .rd_addr_i(rd_addr_i), .rd_hazard_o(rd_hazard_o),
        .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        req_valid_i = v;
        req_addr_i  = a;
        req_wdata_i = d;
        req_be_i    = be;
    endtask

    initial begin
        rstn_i = 1'b0;
        ram_gnt_i = 1'b0;
        rd_addr_i = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        #12;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_we", ram_we_o, 0);
        chk("rst_addr", ram_addr_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_hazard", rd_hazard_o, 0);
        rstn_i = 1'b1;
        step();

        // 1: single store with grant held high
        ram_gnt_i = 1'b1;
        drive(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("t1_we", ram_we_o, 1);
        chk("t1_addr", ram_addr_o, 32'h100);
        chk("t1_data", ram_wdata_o, 32'hDEADBEEF);
        chk("t1_be", ram_be_o, 4'hF);
        chk("t1_count1", count_o, 1);
        chk("t1_empty0", empty_o, 0);
        step();
        chk("t1_count0", count_o, 0);
        chk("t1_empty1", empty_o, 1);
        chk("t1_we0", ram_we_o, 0);
        $display("t1 single store done");

        // 2: fill with grant low, fifth store held
        ram_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h200 + 32'(i) * 32'h10, 32'(i + 1), 4'hF);
            #1;
            chk("t2_ready_fill", req_ready_o, 1);
            step();
            chk("t2_count_fill", count_o, 64'(i + 1));
            $display("t2 push %0d addr=0x%0h", i + 1, req_addr_i);
        end
        drive(1'b1, 32'h240, 32'd5, 4'hF);
        #1;
        chk("t2_ready_full", req_ready_o, 0);
        step();
        chk("t2_count_held", count_o, 4);
        chk("t2_head1", ram_addr_o, 32'h200);
        chk("t2_data1", ram_wdata_o, 1);
        ram_gnt_i = 1'b1;
        step();
        chk("t2_count_pop1", count_o, 3);
        chk("t2_ready_pop1", req_ready_o, 1);
        chk("t2_head2", ram_addr_o, 32'h210);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("t2_count_pushpop", count_o, 3);
        for (int k = 3; k <= 5; k++) begin
            chk("t2_head_order", ram_addr_o, 32'h200 + 32'(k - 1) * 32'h10);
            chk("t2_data_order", ram_wdata_o, 64'(k));
            $display("t2 drain write %0d addr=0x%0h", k, ram_addr_o);
            step();
        end
        chk("t2_drained", count_o, 0);
        chk("t2_we0", ram_we_o, 0);

        // 3: streaming push/pop, ten stores
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i) * 4, 32'hA000 + 32'(i), 4'hF);
            step();
            chk("t3_count", count_o, 1);
            chk("t3_addr", ram_addr_o, 64'(i * 4));
            $display("t3 write addr=0x%0h", ram_addr_o);
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        step();
        chk("t3_drained", count_o, 0);

        // 4: read hazards
        ram_gnt_i = 1'b0;
        drive(1'b1, 32'h204, 32'h1234, 4'hF);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        rd_addr_i = 32'h206;
        #1;
        chk("t4_hit", rd_hazard_o, 1);
        rd_addr_i = 32'h208;
        #1;
        chk("t4_miss", rd_hazard_o, 0);
        drive(1'b1, 32'h208, 32'h5, 4'hF);
        #1;
        chk("t4_push_no_hit", rd_hazard_o, 0);
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        rd_addr_i = 32'h206;
        ram_gnt_i = 1'b1;
        #1;
        chk("t4_pop_still_hit", rd_hazard_o, 1);
        step();
        chk("t4_after_pop", rd_hazard_o, 0);
        chk("t4_count", count_o, 0);
        $display("t4 hazard sequence done");

        // 5: zero byte enables
        ram_gnt_i = 1'b0;
        drive(1'b1, 32'h300, 32'h77, 4'h0);
        #1;
        chk("t5_ready", req_ready_o, 1);
        step();
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("t5_count", count_o, 0);
        chk("t5_we", ram_we_o, 0);
        chk("t5_empty", empty_o, 1);
        $display("t5 zero-be store done");

        // 6: asynchronous reset with pending stores
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h400 + 32'(i) * 4, 32'(i), 4'hF);
            step();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0);
        chk("t6_count3", count_o, 3);
        #2;
        rstn_i = 1'b0;
        #1;
        chk("t6_async_we", ram_we_o, 0);
        chk("t6_async_count", count_o, 0);
        chk("t6_async_empty", empty_o, 1);
        chk("t6_async_addr", ram_addr_o, 0);
        chk("t6_async_ready", req_ready_o, 1);
        step();
        rstn_i = 1'b1;
        ram_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_no_stale_we", ram_we_o, 0);
            chk("t6_no_stale_count", count_o, 0);
        end
        $display("t6 async reset done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
